// File: rtl/c1_pkg.sv
// Shared definitions for the C1 bus responder: command codes, back-end size codes and FSM states.
package c1_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_READ8    = 3'd1;
  localparam logic [2:0] CMD_READ16   = 3'd2;
  localparam logic [2:0] CMD_READ32   = 3'd3;
  localparam logic [2:0] CMD_INV_LINE = 3'd4;
  localparam logic [2:0] CMD_WRITE8   = 3'd5;
  localparam logic [2:0] CMD_WRITE16  = 3'd6;
  localparam logic [2:0] CMD_RESP     = 3'd7;

  localparam logic [1:0] SIZE_8   = 2'd0;
  localparam logic [1:0] SIZE_16  = 2'd1;
  localparam logic [1:0] SIZE_32  = 2'd2;
  localparam logic [1:0] SIZE_INV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A2   = 3'd1,
    ST_TURN = 3'd2,
    ST_BE   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_REL  = 3'd6
  } c1_state_e;

  function automatic logic [1:0] cmd_size(input logic [2:0] cmd);
    case (cmd)
      CMD_READ8,  CMD_WRITE8:  cmd_size = SIZE_8;
      CMD_READ16, CMD_WRITE16: cmd_size = SIZE_16;
      CMD_READ32, CMD_RESP:    cmd_size = SIZE_32;
      CMD_INV_LINE:            cmd_size = SIZE_INV;
      default:                 cmd_size = SIZE_8;
    endcase
  endfunction

  // WRITE32 shares its code with the response command; invalidate is a write to the back-end.
  function automatic logic cmd_is_write(input logic [2:0] cmd);
    cmd_is_write = (cmd == CMD_WRITE8) || (cmd == CMD_WRITE16) ||
                   (cmd == CMD_RESP)   || (cmd == CMD_INV_LINE);
  endfunction

endpackage

// File: rtl/c1_tristate_port.sv
// Registered output-enable and value driving one shared C1 bus; released (Z) whenever oe is low.
module c1_tristate_port #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         oe_nxt,
  input  logic [W-1:0] val_nxt,
  inout  wire  [W-1:0] pad
);

  logic         oe_q;
  logic [W-1:0] val_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe_q  <= 1'b0;
      val_q <= '0;
    end else begin
      oe_q  <= oe_nxt;
      val_q <= val_nxt;
    end
  end

  assign pad = oe_q ? val_q : {W{1'bz}};

endmodule

// File: rtl/c1_bus_responder.sv
// Cache-side responder of the C1 bus: address decode, one back-end req/ack transfer, response phase.
// Optional feature macro: C1_INV_LINE_EN (enables INV_LINE back-end invalidate requests).
module c1_bus_responder
  import c1_pkg::*;
#(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                    data,
  inout  wire  [2:0]                             command,
  output logic                                   be_req,
  output logic                                   be_we,
  output logic [1:0]                             be_size,
  output logic [MEM_ADDR_SIZE-1:0]               be_addr,
  output logic [2*BUS_SIZE-1:0]                  be_wdata,
  input  logic [2*BUS_SIZE-1:0]                  be_rdata,
  input  logic                                   be_ack,
  output logic [2:0]                             dbg_state
);

  localparam int HI_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  c1_state_e                    state, next_state;
  logic [2:0]                   cmd_q;
  logic [HI_W-1:0]              hi_q;
  logic [CACHE_OFFSET_SIZE-1:0] off_q;
  logic                         we_q;
  logic [1:0]                   size_q;
  logic [2*BUS_SIZE-1:0]        wdata_q;
  logic [BUS_SIZE-1:0]          rdata_hi_q;

  logic                         accept;
  logic                         cmd_oe_nxt, data_oe_nxt;
  logic [2:0]                   cmd_val_nxt;
  logic [BUS_SIZE-1:0]          data_val_nxt;

  // X/Z on the command bus matches no item and is treated like NOP.
  always_comb begin
    accept = 1'b0;
    case (command)
      CMD_READ8, CMD_READ16, CMD_READ32,
      CMD_WRITE8, CMD_WRITE16, CMD_RESP: accept = 1'b1;
`ifdef C1_INV_LINE_EN
      CMD_INV_LINE:                      accept = 1'b1;
`else
      CMD_INV_LINE:                      accept = 1'b0;
`endif
      default:                           accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_A2;
      ST_A2:   next_state = ST_TURN;
      ST_TURN: next_state = ST_BE;
      ST_BE:   if (be_ack) next_state = ST_R1;
      ST_R1:   next_state = (cmd_q == CMD_READ32) ? ST_R2 : ST_REL;
      ST_R2:   next_state = ST_REL;
      ST_REL:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Bus drive values are computed from next_state so the port registers change on the same edge as the FSM.
  always_comb begin
    cmd_oe_nxt   = (next_state == ST_BE) || (next_state == ST_R1) || (next_state == ST_R2);
    cmd_val_nxt  = (next_state == ST_BE) ? CMD_NOP : CMD_RESP;
    data_oe_nxt  = !we_q && ((next_state == ST_R1) || (next_state == ST_R2));
    data_val_nxt = rdata_hi_q;
    if (next_state == ST_R1) begin
      if (cmd_q == CMD_READ8) data_val_nxt = {{(BUS_SIZE-8){1'b0}}, be_rdata[7:0]};
      else                    data_val_nxt = be_rdata[BUS_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q      <= CMD_NOP;
      hi_q       <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= SIZE_8;
      wdata_q    <= '0;
      rdata_hi_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cmd_q  <= command;
          hi_q   <= address;
          we_q   <= cmd_is_write(command);
          size_q <= cmd_size(command);
          if (command == CMD_WRITE8)
            wdata_q <= {{(2*BUS_SIZE-8){1'b0}}, data[7:0]};
          else if ((command == CMD_WRITE16) || (command == CMD_RESP))
            wdata_q <= {{BUS_SIZE{1'b0}}, data};
          else
            wdata_q <= '0;
        end
        ST_A2: begin
          off_q <= address[CACHE_OFFSET_SIZE-1:0];
          if (cmd_q == CMD_RESP) wdata_q[2*BUS_SIZE-1:BUS_SIZE] <= data;
        end
        ST_BE: if (be_ack) rdata_hi_q <= be_rdata[2*BUS_SIZE-1:BUS_SIZE];
        default: ;
      endcase
    end
  end

  assign be_req    = (state == ST_BE);
  assign be_we     = we_q;
  assign be_size   = size_q;
  assign be_addr   = {hi_q, off_q};
  assign be_wdata  = wdata_q;
  assign dbg_state = state;

  c1_tristate_port #(.W(3)) u_cmd_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .oe_nxt  (cmd_oe_nxt),
    .val_nxt (cmd_val_nxt),
    .pad     (command)
  );

  c1_tristate_port #(.W(BUS_SIZE)) u_data_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .oe_nxt  (data_oe_nxt),
    .val_nxt (data_val_nxt),
    .pad     (data)
  );

endmodule
